psum_accum_ctrl: RTL
====================

Name: psum_accum_ctrl

Overview:
- Read-modify-write sequencer for PL Port A of the output partial-sum BRAM.
- Accepts a stream of (address, partial sum, first-flag) beats from the PE array.
- For each beat, reads the stored word, adds the beat to it, and writes the result back. When `IN_FIRST` is set, it overwrites the word instead.
- Counts beats per tile and raises `DONE` so the PS can read results through Port B, which this block does not touch.

Parameters:
- BW, 32, data width of a BRAM word and of `IN_DATA` (two's complement)
- AW, 10, BRAM address width
- CW, 16, width of the beat counter / `NUM_BEATS`

Ports:
- CLK  input  1  clock
- RSTN  input  1  asynchronous active-low reset
- START  input  1  one-cycle pulse; arms a tile; sampled only in IDLE or DONE
- NUM_BEATS  input  CW  beats in the tile; sampled on START; 0 means immediate DONE
- IN_VALID  input  1  beat valid
- IN_READY  output  1  beat accepted when IN_VALID && IN_READY at posedge
- IN_ADDR  input  AW  target word address
- IN_DATA  input  BW  signed partial sum
- IN_FIRST  input  1  1 = write IN_DATA (ignore stored value); 0 = accumulate
- EN_A  output  1  BRAM Port A enable
- WE_A  output  1  BRAM Port A write enable
- ADDR_A  output  AW  BRAM Port A address
- DIN_A  output  BW  BRAM Port A write data
- DOUT_A  input  BW  BRAM Port A read data (1-cycle registered read)
- BUSY  output  1  high from accepted START until DONE
- DONE  output  1  level; high after last write until next accepted START
- OVF  output  1  sticky signed-overflow flag for the tile; cleared on START

Behaviour:
- Reset (RSTN=0, asynchronous): state IDLE; IN_READY, EN_A, WE_A, BUSY, DONE and OVF all 0; ADDR_A and DIN_A 0.
  - Reset mid-tile abandons the tile. BRAM contents are then unspecified; an in-flight write may or may not have landed.
- States: IDLE, ACCEPT, RD, WR, DONE.
- IDLE/DONE + START:
  - Load the remaining-beat counter from NUM_BEATS and clear OVF.
  - If NUM_BEATS=0: go to DONE with DONE=1 on the next cycle.
  - Otherwise: go to ACCEPT, BUSY=1, DONE=0.
- ACCEPT:
  - IN_READY=1; EN_A=0.
  - On handshake: latch addr/data/first, go to RD.
- RD:
  - Drive EN_A=1, WE_A=0, ADDR_A=latched addr; IN_READY=0.
  - Next state is WR.
- WR:
  - DOUT_A is valid in this cycle.
  - Drive EN_A=1, WE_A=1, ADDR_A=latched addr, DIN_A = first ? data : DOUT_A + data.
  - Decrement the counter.
  - If the counter reaches 0: go to DONE and keep IN_READY=0.
  - Otherwise: IN_READY=1 in this cycle. A handshake here latches the next beat and goes straight to RD; with no handshake, go to ACCEPT.
- Throughput and latency:
  - Steady-state throughput is 1 beat per 2 cycles.
  - Latency from handshake to write-enable cycle is 2 cycles.
- Hazards: a write in WR commits at the posedge ending WR, before any later RD samples. Back-to-back beats to the same address therefore accumulate correctly with no forwarding.
- Arithmetic:
  - BW-bit two's complement.
  - Overflow is detected as operands of equal sign producing a result of different sign; it sets OVF (accumulate only, never on first).
  - The default result wraps.
- Edge handling:
  - START in ACCEPT/RD/WR is ignored.
  - IN_VALID outside ACCEPT/WR is not consumed.
  - Extra beats after the count are never accepted.
- DONE→START re-arms without passing through IDLE.

Optional Feature:
- Macro PSUM_SAT_EN.
  - Defined: on overflow, DIN_A saturates to the maximum (0x7FFF_FFFF for BW=32) or minimum (0x8000_0000) signed value; OVF is still set.
  - Undefined: the result wraps modulo 2^BW; OVF behaviour is identical.

Test Plan:
- Reset, then START with NUM_BEATS=0 → DONE=1 one cycle later, BUSY=0, EN_A never asserted.
- START with NUM_BEATS=1, beat addr=5, data=7, first=1 → RD cycle at addr 5, then WR with DIN_A=7; DONE=1; PS Port B read of addr 5 returns 7.
- NUM_BEATS=3, beats to addr 3:
  - Stimulus: (10, first) then (−4) then (100), IN_VALID held high.
  - Response: writes 10, 6, 106; beats accepted every 2 cycles; final word 106; OVF=0.
- Addr 0 preloaded with 0x7FFF_FFFF, beat +1 non-first:
  - PSUM_SAT_EN undefined → writes 0x8000_0000, OVF=1.
  - PSUM_SAT_EN defined → writes 0x7FFF_FFFF, OVF=1.
- IN_VALID gaps and START pulses mid-tile (NUM_BEATS=2) → START ignored; DONE only after the 2nd WR; no write while IN_VALID is low.
- RSTN low during an RD cycle → all outputs 0 immediately; IN_READY=0; after release, the next START runs a full tile normally.

Source files
------------

// File: rtl/psum_accum_ctrl_if.sv
// rtl/psum_accum_ctrl_if.sv - beat stream and BRAM Port A bundle for psum_accum_ctrl
//
// Purpose: groups the PE-array beat handshake and the BRAM Port A signals.
// Signals:
//   in_valid/in_ready      beat handshake (accepted when both high at posedge)
//   in_addr/in_data/in_first  beat payload: word address, signed partial sum, overwrite flag
//   en_a/we_a/addr_a/din_a  BRAM Port A enable, write enable, address, write data
//   dout_a                 BRAM Port A read data (1-cycle registered read)
// Modports:
//   slave  - the sequencer (consumes beats, drives Port A)
//   master - the surrounding PE array / BRAM side
interface psum_accum_ctrl_if #(
  parameter int BW = 32,
  parameter int AW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [BW-1:0] in_data;
  logic          in_first;
  logic          en_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [BW-1:0] din_a;
  logic [BW-1:0] dout_a;

  modport slave (
    input  in_valid, in_addr, in_data, in_first, dout_a,
    output in_ready, en_a, we_a, addr_a, din_a
  );

  modport master (
    output in_valid, in_addr, in_data, in_first, dout_a,
    input  in_ready, en_a, we_a, addr_a, din_a
  );
endinterface

// File: rtl/psum_accum_ctrl.sv
// rtl/psum_accum_ctrl.sv - read-modify-write partial-sum accumulator for BRAM Port A
//
// Purpose: for each accepted beat, reads the stored word, adds the beat (or
// overwrites it when in_first is set) and writes the result back. Counts beats
// per tile and holds done once the last write has been issued.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   start       one-cycle pulse arming a tile (honoured only in IDLE/DONE)
//   num_beats   beats in the tile, sampled on start; 0 gives immediate done
//   bus         psum_accum_ctrl_if.slave: beat stream + BRAM Port A
//   busy        high from accepted start until done
//   done        level, high after the last write until the next accepted start
//   ovf         sticky signed-overflow flag for the tile, cleared on start
// Optional feature: define PSUM_SAT_EN to saturate overflowing sums instead of wrapping.
module psum_accum_ctrl #(
  parameter int BW = 32,
  parameter int AW = 10,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [CW-1:0]       num_beats,
  psum_accum_ctrl_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] lat_data;
  logic          lat_first;
  logic          in_ready_q;
  logic          en_a_q;
  logic          we_a_q;
  logic [AW-1:0] addr_a_q;

  logic [BW-1:0] sum;
  logic          ovf_det;
  logic [BW-1:0] wr_value;
  logic          last_beat;

  assign bus.in_ready = in_ready_q;
  assign bus.en_a     = en_a_q;
  assign bus.we_a     = we_a_q;
  assign bus.addr_a   = addr_a_q;

  // Read data only arrives in WR, so the write word is formed combinationally
  // from dout_a and driven only in that state.
  assign bus.din_a = (state == S_WR) ? wr_value : '0;

  assign last_beat = (cnt == CW'(1));

  always_comb begin
    sum     = bus.dout_a + lat_data;
    ovf_det = 1'b0;
    if (!lat_first) begin
      ovf_det = (bus.dout_a[BW-1] == lat_data[BW-1]) && (sum[BW-1] != lat_data[BW-1]);
    end
    if (lat_first) begin
      wr_value = lat_data;
    end else begin
`ifdef PSUM_SAT_EN
      if (ovf_det) begin
        // Both operands share a sign on overflow; saturate toward that sign.
        wr_value = lat_data[BW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      end else begin
        wr_value = sum;
      end
`else
      wr_value = sum;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_data   <= '0;
      lat_first  <= 1'b0;
      in_ready_q <= 1'b0;
      en_a_q     <= 1'b0;
      we_a_q     <= 1'b0;
      addr_a_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt <= num_beats;
            ovf <= 1'b0;
            if (num_beats == '0) begin
              state      <= S_DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              in_ready_q <= 1'b0;
            end else begin
              state      <= S_ACCEPT;
              done       <= 1'b0;
              busy       <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          if (bus.in_valid && in_ready_q) begin
            addr_a_q   <= bus.in_addr;
            lat_data   <= bus.in_data;
            lat_first  <= bus.in_first;
            in_ready_q <= 1'b0;
            en_a_q     <= 1'b1;
            we_a_q     <= 1'b0;
            state      <= S_RD;
          end
        end

        S_RD: begin
          en_a_q     <= 1'b1;
          we_a_q     <= 1'b1;
          // Ready during WR only if another beat is still owed.
          in_ready_q <= !last_beat;
          state      <= S_WR;
        end

        S_WR: begin
          cnt <= cnt - CW'(1);
          if (ovf_det) begin
            ovf <= 1'b1;
          end
          if (last_beat) begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            en_a_q     <= 1'b0;
            we_a_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end else if (bus.in_valid) begin
            // Overlap: next beat is latched while this write commits.
            addr_a_q   <= bus.in_addr;
            lat_data   <= bus.in_data;
            lat_first  <= bus.in_first;
            in_ready_q <= 1'b0;
            en_a_q     <= 1'b1;
            we_a_q     <= 1'b0;
            state      <= S_RD;
          end else begin
            en_a_q     <= 1'b0;
            we_a_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= S_ACCEPT;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
